// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// FETCH_ALIGN_CHECK_EN adds the HALT state used on misaligned redirect targets.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int OPC_W  = 7;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
`ifdef FETCH_ALIGN_CHECK_EN
        , ST_HALT
`endif
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_REDIR
    } pc_sel_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// Fetch program counter: holds, advances by one word, or loads a redirect target.
module pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_sel_e     sel_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_pc_o
);

    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;

    // The +4 wraps naturally at 2^32.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        case (sel_i)
            PC_INC:   fetch_pc_d = fetch_pc_q + 32'd4;
            PC_REDIR: fetch_pc_d = redirect_pc_i;
            default:  fetch_pc_d = fetch_pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit with branch redirect and a one-entry hold buffer.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets into a sticky HALT.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [OPC_W-1:0]  opcode,
    output logic [31:0]       pc,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              misalign_err
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [31:0]       pc_q, pc_d;
    logic              req_q;
    logic              valid_q;
    pc_sel_e           pc_sel;
    logic [31:0]       fetch_pc;
    logic [31:0]       target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              err_q, err_d;
    assign target = redirect_pc;
`else
    assign target = redirect_pc & 32'hFFFF_FFFC;
`endif

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel_i         (pc_sel),
        .redirect_pc_i (target),
        .fetch_pc_o    (fetch_pc)
    );

    // The redirect target is written into fetch_pc immediately; drop_q remembers
    // that the response still in flight belongs to the abandoned path.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        pc_sel  = PC_HOLD;
`ifdef FETCH_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect) pc_sel = PC_REDIR;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                    drop_d  = redirect;
                end
                if (redirect) pc_sel = PC_REDIR;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                        inst_d  = imem_rdata;
                        pc_d    = fetch_pc;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
                if (redirect) pc_sel = PC_REDIR;
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = ST_REQ;
                    pc_sel  = PC_REDIR;
                end else if (inst_ready) begin
                    state_d = ST_REQ;
                    pc_sel  = PC_INC;
                end
            end
            default: state_d = state_q;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect && is_misaligned(redirect_pc) && state_q != ST_HALT) begin
            state_d = ST_HALT;
            pc_sel  = PC_HOLD;
            drop_d  = 1'b0;
            inst_d  = inst_q;
            pc_d    = pc_q;
            err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            inst_q  <= NOP;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            req_q   <= (state_d == ST_REQ);
            valid_q <= (state_d == ST_HOLD);
`ifdef FETCH_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = fetch_pc;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign opcode     = inst_q[OPC_W-1:0];
    assign pc         = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed sequences, a vector table, and a randomized run
// against a transaction-level model of the expected fetch stream.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign_err;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .opcode       (opcode),
        .pc           (pc),
        .inst_ready   (inst_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic [31:0] target;
        logic [31:0] rdata;
        logic [6:0]  opc;
        logic [31:0] next;
    } vec_t;

    vec_t tbl[5];
    int   nvec = 0;
    int   nerr = 0;

    logic [31:0] exp_pc;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic [31:0] out_addr;
    logic        prev_valid;
    logic        outstanding;
    int          wcnt;
    int          ndeliv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic serve(input logic [31:0] d);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        cyc();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0200, 32'h0000_2003, 7'b0000011, 32'h0000_0204};
        tbl[1] = '{32'h0000_1000, 32'h0011_2023, 7'b0100011, 32'h0000_1004};
        tbl[2] = '{32'hFFFF_FFFC, 32'hFE00_0EE3, 7'b1100011, 32'h0000_0000};
        tbl[3] = '{32'h7FFF_FFFC, 32'h0000_0013, 7'b0010011, 32'h8000_0000};
        tbl[4] = '{32'h0000_0ABC, 32'h00B5_0533, 7'b0110011, 32'h0000_0AC0};

        // Reset values and first fetch with gnt held high.
        repeat (2) cyc();
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_inst",  inst, 32'h0000_0013);
        chk("rst_err",   32'(misalign_err), 32'h0);
        imem_gnt = 1'b1;
        rst_n    = 1'b1;
        chk("idle_req",  32'(imem_req), 32'h0);
        cyc();
        chk("first_req",  32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        cyc();
        chk("wait_req",   32'(imem_req), 32'h0);
        chk("wait_valid", 32'(inst_valid), 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        cyc();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        chk("lat_valid", 32'(inst_valid), 32'h1);
        chk("lat_opc",   32'(opcode), 32'h33);
        chk("lat_pc",    pc, 32'h0);

        // Stall in HOLD, then consume.
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_inst",  inst, 32'h0000_0033);
            chk("stall_pc",    pc, 32'h0);
            chk("stall_req",   32'(imem_req), 32'h0);
            chk("stall_valid", 32'(inst_valid), 32'h1);
        end
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        chk("seq_req",   32'(imem_req), 32'h1);
        chk("seq_addr",  imem_addr, 32'h4);
        chk("seq_valid", 32'(inst_valid), 32'h0);

        // Redirect while waiting: response is dropped.
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        chk("drop_mid_req",   32'(imem_req), 32'h0);
        chk("drop_mid_valid", 32'(inst_valid), 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0003;
        cyc();
        imem_rvalid = 1'b0;
        chk("drop_valid", 32'(inst_valid), 32'h0);
        chk("drop_req",   32'(imem_req), 32'h1);
        chk("drop_addr",  imem_addr, 32'h100);

        // Redirect in REQ without gnt, then redirect+ready in HOLD.
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        cyc();
        redirect = 1'b0;
        chk("reqredir_addr", imem_addr, 32'h8);
        serve(32'h0000_0013);
        chk("hold8_valid", 32'(inst_valid), 32'h1);
        chk("hold8_pc",    pc, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        inst_ready  = 1'b1;
        cyc();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        chk("holdredir_valid", 32'(inst_valid), 32'h0);
        chk("holdredir_addr",  imem_addr, 32'h40);

        // Redirect coincident with gnt.
        imem_gnt    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h600;
        cyc();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        chk("gntredir_req", 32'(imem_req), 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5033;
        cyc();
        imem_rvalid = 1'b0;
        chk("gntredir_valid", 32'(inst_valid), 32'h0);
        chk("gntredir_addr",  imem_addr, 32'h600);

        // Redirect coincident with rvalid.
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        cyc();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        chk("rvredir_valid", 32'(inst_valid), 32'h0);
        chk("rvredir_addr",  imem_addr, 32'h500);

        for (int i = 0; i < 5; i++) begin
            redirect    = 1'b1;
            redirect_pc = tbl[i].target;
            cyc();
            redirect = 1'b0;
            chk("tbl_addr", imem_addr, tbl[i].target);
            serve(tbl[i].rdata);
            chk("tbl_valid", 32'(inst_valid), 32'h1);
            chk("tbl_opc",   32'(opcode), 32'(tbl[i].opc));
            chk("tbl_pc",    pc, tbl[i].target);
            imem_rvalid = 1'b1;
            imem_rdata  = ~tbl[i].rdata;
            cyc();
            imem_rvalid = 1'b0;
            chk("tbl_ignore_rv", inst, tbl[i].rdata);
            inst_ready = 1'b1;
            cyc();
            inst_ready = 1'b0;
            chk("tbl_next_req",  32'(imem_req), 32'h1);
            chk("tbl_next_addr", imem_addr, tbl[i].next);
        end

        // Reset mid-transaction, stale rvalid, redirect in IDLE.
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("arst_pc",   pc, 32'h0);
        chk("arst_inst", inst, 32'h0000_0013);
        cyc();
        rst_n       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        cyc();
        redirect = 1'b0;
        chk("idleredir_addr",  imem_addr, 32'h80);
        chk("idleredir_valid", 32'(inst_valid), 32'h0);
        cyc();
        imem_rvalid = 1'b0;
        chk("stale_rv_valid", 32'(inst_valid), 32'h0);
        chk("stale_rv_req",   32'(imem_req), 32'h1);

        // Misaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        cyc();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_err", 32'(misalign_err), 32'h1);
        imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("halt_req",   32'(imem_req), 32'h0);
            chk("halt_valid", 32'(inst_valid), 32'h0);
            cyc();
        end
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("halt_rst_err", 32'(misalign_err), 32'h0);
`else
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_err",  32'(misalign_err), 32'h0);
`endif

        // Randomized run against the fetch-stream model.
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n       = 1'b1;
        exp_pc      = 32'h0;
        prev_valid  = 1'b0;
        outstanding = 1'b0;
        wcnt        = 0;
        ndeliv      = 0;
        hold_inst   = 32'h0;
        hold_pc     = 32'h0;
        out_addr    = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            if (imem_req) chk("rnd_addr", imem_addr, exp_pc);
            if (imem_req && inst_valid) chk("rnd_req_and_valid", 32'h1, 32'h0);
            if (inst_valid && !prev_valid) begin
                ndeliv++;
                chk("rnd_pc",   pc, exp_pc);
                chk("rnd_inst", inst, memval(exp_pc));
                hold_inst = inst;
                hold_pc   = pc;
            end else if (inst_valid) begin
                chk("rnd_hold_inst", inst, hold_inst);
                chk("rnd_hold_pc",   pc, hold_pc);
            end
            prev_valid = inst_valid;

            imem_rvalid = 1'b0;
            imem_gnt    = 1'b0;
            if (outstanding) begin
                if (wcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memval(out_addr);
                    outstanding = 1'b0;
                end else begin
                    wcnt--;
                end
            end else if ($urandom_range(9) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
            end
            if (imem_req && $urandom_range(2) != 0) begin
                imem_gnt    = 1'b1;
                outstanding = 1'b1;
                wcnt        = $urandom_range(2);
                out_addr    = imem_addr;
            end
            inst_ready = ($urandom_range(2) == 0);
            redirect   = ($urandom_range(15) == 0);
            case ($urandom_range(2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: redirect_pc = 32'($urandom_range(1023));
            endcase
`ifdef FETCH_ALIGN_CHECK_EN
            redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
            if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
            cyc();
        end
        redirect   = 1'b0;
        inst_ready = 1'b0;
        nvec++;
        if (ndeliv < 50) begin
            nerr++;
            $display("FAIL rnd_progress: got %0d deliveries, expected at least 50", ndeliv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
